node_interface: RTL and testbench

- Node-side endpoint of the mesh/torus fabric. It is the other end of the network's per-node port: it drives nodeToNetwork* and consumes networkToNode*.
- Client transmit packets are buffered in a TX FIFO, given a source/destination header, and injected under the router's hold back-pressure.
- Ejected packets are buffered in an RX FIFO. The block asserts hold towards the network when that FIFO is full, and checks each packet's destination against its own location.
- One instance per node, one per router port 4.

---
 rtl/node_pkg.sv | 48 ++++
 rtl/node_if.sv | 48 ++++
 rtl/nic_fifo.sv | 53 +++++
 rtl/node_interface.sv | 98 +++++++++
 tb/tb_node_interface.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/node_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// node_pkg : shared header layout and helpers for the fabric node interface
// Revision : 1.0
// ----------------------------------------------------------------------------
package node_pkg;

  localparam int ADDR_BITS  = 3;
  localparam int c_HDR_BITS = 4 * ADDR_BITS;

  // Bit offsets of each field inside the 12-bit header (header sits at the packet MSBs)
  localparam int c_DEST_X_OFS = 3 * ADDR_BITS;
  localparam int c_DEST_Y_OFS = 2 * ADDR_BITS;
  localparam int c_SRC_X_OFS  = 1 * ADDR_BITS;
  localparam int c_SRC_Y_OFS  = 0;

  typedef struct packed {
    logic [ADDR_BITS-1:0] destX;
    logic [ADDR_BITS-1:0] destY;
    logic [ADDR_BITS-1:0] srcX;
    logic [ADDR_BITS-1:0] srcY;
  } nodeHeader_t;

  function automatic nodeHeader_t buildHeader(input logic [ADDR_BITS-1:0] destX,
                                              input logic [ADDR_BITS-1:0] destY,
                                              input int                   srcX,
                                              input int                   srcY);
    nodeHeader_t hdr;
    hdr.destX = destX;
    hdr.destY = destY;
    hdr.srcX  = ADDR_BITS'(srcX);
    hdr.srcY  = ADDR_BITS'(srcY);
    return hdr;
  endfunction

  function automatic logic destInMesh(input logic [ADDR_BITS-1:0] destX,
                                      input logic [ADDR_BITS-1:0] destY,
                                      input int                   xNodes,
                                      input int                   yNodes);
    return ($unsigned(xNodes) > 32'(destX)) && ($unsigned(yNodes) > 32'(destY));
  endfunction

  function automatic logic isLocal(input nodeHeader_t hdr, input int xLoc, input int yLoc);
    return (hdr.destX == ADDR_BITS'(xLoc)) && (hdr.destY == ADDR_BITS'(yLoc));
  endfunction

endpackage
`default_nettype wire

// File: rtl/node_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// node_if : client TX/RX handshakes plus the router-facing port of one node
// Revision : 1.0
// ----------------------------------------------------------------------------
interface node_if
  import node_pkg::*;
#(
  parameter int FIFO_WIDTH = 64
) ();

  logic [FIFO_WIDTH-c_HDR_BITS-1:0] txPayload;
  logic [ADDR_BITS-1:0]             txDestX;
  logic [ADDR_BITS-1:0]             txDestY;
  logic                             txValid;
  logic                             txReady;

  logic [FIFO_WIDTH-1:0]            nodeToNetworkData;
  logic                             nodeToNetworkWriteRequest;
  logic                             nodeToNetworkHoldRequest;
  logic [FIFO_WIDTH-1:0]            networkToNodeData;
  logic                             networkToNodeWriteRequest;
  logic                             networkToNodeHoldRequest;

  logic [FIFO_WIDTH-1:0]            rxData;
  logic                             rxValid;
  logic                             rxReady;

  modport master (
    input  txPayload, txDestX, txDestY, txValid,
    input  networkToNodeData, networkToNodeWriteRequest, networkToNodeHoldRequest,
    input  rxReady,
    output txReady,
    output nodeToNetworkData, nodeToNetworkWriteRequest, nodeToNetworkHoldRequest,
    output rxData, rxValid
  );

  modport slave (
    output txPayload, txDestX, txDestY, txValid,
    output networkToNodeData, networkToNodeWriteRequest, networkToNodeHoldRequest,
    output rxReady,
    input  txReady,
    input  nodeToNetworkData, nodeToNetworkWriteRequest, nodeToNetworkHoldRequest,
    input  rxData, rxValid
  );

endinterface
`default_nettype wire

// File: rtl/nic_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nic_fifo : pointer FIFO (DEPTH power of 2, >= 2); head reads 0 when empty
// Revision : 1.0
// ----------------------------------------------------------------------------
module nic_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int             c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_PTR_ONE = 1;

  logic [c_AW:0]    r_wrPtr;
  logic [c_AW:0]    r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Extra pointer MSB separates the full case from the empty case
  assign empty = (r_wrPtr == r_rdPtr);
  assign full  = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                 (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);
  assign head  = empty ? '0 : r_mem[r_rdPtr[c_AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + c_PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr[c_AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/node_interface.sv
`default_nettype none
// ----------------------------------------------------------------------------
// node_interface : node-side fabric endpoint with TX/RX FIFOs and statistics
// Revision : 1.0
// ----------------------------------------------------------------------------
module node_interface
  import node_pkg::*;
#(
  parameter int X_LOC       = 0,
  parameter int Y_LOC       = 0,
  parameter int X_NODES     = 3,
  parameter int Y_NODES     = 3,
  parameter int FIFO_WIDTH  = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  node_if.master                 bus,
  output logic [COUNT_WIDTH-1:0] txDropCount,
  output logic [COUNT_WIDTH-1:0] rxOverflowCount,
  output logic [COUNT_WIDTH-1:0] misrouteCount
);

  localparam logic [COUNT_WIDTH-1:0] c_CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] c_CNT_ONE = 1;

  logic                  w_txFull, w_txEmpty, w_txAccept, w_txLegal, w_txPush, w_txDrop, w_txPop;
  logic [FIFO_WIDTH-1:0] w_txDin, w_txHead;
  logic                  w_rxFull, w_rxEmpty, w_rxPush, w_rxOverflow, w_rxMisroute, w_rxPop;
  logic [FIFO_WIDTH-1:0] w_rxHead;
  nodeHeader_t           w_txHdr, w_rxHdr;

  // TX: illegal destinations are consumed from the client but never stored
  assign w_txLegal  = destInMesh(bus.txDestX, bus.txDestY, X_NODES, Y_NODES);
  assign w_txAccept = bus.txValid && !w_txFull;
  assign w_txPush   = w_txAccept && w_txLegal;
  assign w_txDrop   = w_txAccept && !w_txLegal;
  assign w_txHdr    = buildHeader(bus.txDestX, bus.txDestY, X_LOC, Y_LOC);
  assign w_txDin    = {w_txHdr, bus.txPayload};

  // Router hold gates injection combinationally in the same cycle
  assign w_txPop    = !w_txEmpty && !bus.networkToNodeHoldRequest;

  assign bus.txReady                   = !w_txFull;
  assign bus.nodeToNetworkData         = w_txHead;
  assign bus.nodeToNetworkWriteRequest = w_txPop;

  nic_fifo #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) u_txFifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_txPush),
    .pop   (w_txPop),
    .din   (w_txDin),
    .head  (w_txHead),
    .full  (w_txFull),
    .empty (w_txEmpty)
  );

  // RX: a write while full is lost even if the client pops in that cycle
  assign w_rxHdr      = nodeHeader_t'(bus.networkToNodeData[FIFO_WIDTH-1 -: c_HDR_BITS]);
  assign w_rxPush     = bus.networkToNodeWriteRequest && !w_rxFull;
  assign w_rxOverflow = bus.networkToNodeWriteRequest && w_rxFull;
  assign w_rxMisroute = w_rxPush && !isLocal(w_rxHdr, X_LOC, Y_LOC);
  assign w_rxPop      = !w_rxEmpty && bus.rxReady;

  assign bus.nodeToNetworkHoldRequest = w_rxFull;
  assign bus.rxValid                  = !w_rxEmpty;
  assign bus.rxData                   = w_rxHead;

  nic_fifo #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) u_rxFifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_rxPush),
    .pop   (w_rxPop),
    .din   (bus.networkToNodeData),
    .head  (w_rxHead),
    .full  (w_rxFull),
    .empty (w_rxEmpty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txDropCount     <= '0;
      rxOverflowCount <= '0;
      misrouteCount   <= '0;
    end else begin
      if (w_txDrop && (txDropCount != c_CNT_MAX))
        txDropCount <= txDropCount + c_CNT_ONE;
      if (w_rxOverflow && (rxOverflowCount != c_CNT_MAX))
        rxOverflowCount <= rxOverflowCount + c_CNT_ONE;
      if (w_rxMisroute && (misrouteCount != c_CNT_MAX))
        misrouteCount <= misrouteCount + c_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_node_interface.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_node_interface : directed bench for node_interface at node (1,1) of 3x3
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_node_interface;

  localparam int W = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  node_if #(.FIFO_WIDTH(W)) bus  ();
  node_if #(.FIFO_WIDTH(W)) bus2 ();

  logic [15:0] txDropCount, rxOverflowCount, misrouteCount;
  logic [1:0]  satDrop, satOvf, satMis;

  int nTests = 0;
  int nFail  = 0;

  node_interface #(
    .X_LOC(1), .Y_LOC(1), .X_NODES(3), .Y_NODES(3),
    .FIFO_WIDTH(W), .FIFO_DEPTH(4), .COUNT_WIDTH(16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .txDropCount     (txDropCount),
    .rxOverflowCount (rxOverflowCount),
    .misrouteCount   (misrouteCount)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles
  node_interface #(
    .X_LOC(1), .Y_LOC(1), .X_NODES(3), .Y_NODES(3),
    .FIFO_WIDTH(W), .FIFO_DEPTH(4), .COUNT_WIDTH(2)
  ) dut2 (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus2),
    .txDropCount     (satDrop),
    .rxOverflowCount (satOvf),
    .misrouteCount   (satMis)
  );

  function automatic logic [63:0] mkPkt(input logic [2:0] dx, input logic [2:0] dy,
                                        input logic [2:0] sx, input logic [2:0] sy,
                                        input logic [51:0] pl);
    return {dx, dy, sx, sy, pl};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nTests++; if (bus.txReady !== 1'b1) begin nFail++; $display("FAIL reset_txReady: got %b exp 1", bus.txReady); end
    nTests++; if (bus.nodeToNetworkWriteRequest !== 1'b0) begin nFail++; $display("FAIL reset_writeReq: got %b exp 0", bus.nodeToNetworkWriteRequest); end
    nTests++; if (bus.nodeToNetworkHoldRequest !== 1'b0) begin nFail++; $display("FAIL reset_hold: got %b exp 0", bus.nodeToNetworkHoldRequest); end
    nTests++; if (bus.rxValid !== 1'b0) begin nFail++; $display("FAIL reset_rxValid: got %b exp 0", bus.rxValid); end
    nTests++; if (bus.nodeToNetworkData !== 64'h0) begin nFail++; $display("FAIL reset_netData: got %h exp 0", bus.nodeToNetworkData); end
    nTests++; if (bus.rxData !== 64'h0) begin nFail++; $display("FAIL reset_rxData: got %h exp 0", bus.rxData); end
    nTests++; if ({txDropCount, rxOverflowCount, misrouteCount} !== 48'h0) begin nFail++; $display("FAIL reset_counters: got %h exp 0", {txDropCount, rxOverflowCount, misrouteCount}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_inject();
    bus.networkToNodeHoldRequest = 1'b0;
    bus.txValid = 1'b1; bus.txDestX = 3'd2; bus.txDestY = 3'd0; bus.txPayload = 52'h5A;
    #1;
    nTests++; if (bus.nodeToNetworkWriteRequest !== 1'b0) begin nFail++; $display("FAIL inject_nobypass: got %b exp 0", bus.nodeToNetworkWriteRequest); end
    @(posedge clk); #1;
    bus.txValid = 1'b0;
    #1;
    nTests++; if (bus.nodeToNetworkWriteRequest !== 1'b1) begin nFail++; $display("FAIL inject_writeReq: got %b exp 1", bus.nodeToNetworkWriteRequest); end
    nTests++; if (bus.nodeToNetworkData[63:52] !== 12'b010_000_001_001) begin nFail++; $display("FAIL inject_header: got %h exp 409", bus.nodeToNetworkData[63:52]); end
    nTests++; if (bus.nodeToNetworkData[51:0] !== 52'h5A) begin nFail++; $display("FAIL inject_payload: got %h exp 5a", bus.nodeToNetworkData[51:0]); end
    step();
    nTests++; if (bus.nodeToNetworkWriteRequest !== 1'b0) begin nFail++; $display("FAIL inject_popped: got %b exp 0", bus.nodeToNetworkWriteRequest); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      bus.txValid = 1'b1; bus.txDestX = 3'd0; bus.txDestY = 3'd0; bus.txPayload = 52'h30 + 52'(i);
      step();
      nTests++;
      if (bus.nodeToNetworkWriteRequest !== 1'b1 || bus.nodeToNetworkData !== mkPkt(3'd0, 3'd0, 3'd1, 3'd1, 52'h30 + 52'(i))) begin
        nFail++; $display("FAIL b2b_pkt%0d: got wr=%b data=%h exp wr=1 data=%h", i, bus.nodeToNetworkWriteRequest,
                          bus.nodeToNetworkData, mkPkt(3'd0, 3'd0, 3'd1, 3'd1, 52'h30 + 52'(i)));
      end
    end
    bus.txValid = 1'b0;
    step();
    nTests++; if (bus.nodeToNetworkWriteRequest !== 1'b0) begin nFail++; $display("FAIL b2b_drained: got %b exp 0", bus.nodeToNetworkWriteRequest); end
  endtask

  task automatic test_backpressure();
    logic expReady;
    bus.networkToNodeHoldRequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.txValid = 1'b1; bus.txDestX = 3'd1; bus.txDestY = 3'd2; bus.txPayload = 52'h100 + 52'(i);
      expReady = (i < 4);
      #1;
      nTests++;
      if (bus.txReady !== expReady || bus.nodeToNetworkWriteRequest !== 1'b0) begin
        nFail++; $display("FAIL bp_fill%0d: got ready=%b wr=%b exp ready=%b wr=0", i, bus.txReady,
                          bus.nodeToNetworkWriteRequest, expReady);
      end
      step();
    end
    bus.txValid = 1'b0;
    bus.networkToNodeHoldRequest = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      nTests++;
      if (bus.nodeToNetworkWriteRequest !== 1'b1 || bus.nodeToNetworkData !== mkPkt(3'd1, 3'd2, 3'd1, 3'd1, 52'h100 + 52'(i))) begin
        nFail++; $display("FAIL bp_drain%0d: got wr=%b data=%h exp wr=1 data=%h", i, bus.nodeToNetworkWriteRequest,
                          bus.nodeToNetworkData, mkPkt(3'd1, 3'd2, 3'd1, 3'd1, 52'h100 + 52'(i)));
      end
      step();
    end
    nTests++; if (bus.nodeToNetworkWriteRequest !== 1'b0 || bus.txReady !== 1'b1) begin nFail++; $display("FAIL bp_empty: got wr=%b ready=%b exp wr=0 ready=1", bus.nodeToNetworkWriteRequest, bus.txReady); end
  endtask

  task automatic test_drop();
    bus.txValid = 1'b1; bus.txDestX = 3'd3; bus.txDestY = 3'd1; bus.txPayload = 52'h77;
    step();
    bus.txValid = 1'b0;
    #1;
    nTests++; if (txDropCount !== 16'd1 || bus.nodeToNetworkWriteRequest !== 1'b0) begin nFail++; $display("FAIL drop_x: got cnt=%0d wr=%b exp cnt=1 wr=0", txDropCount, bus.nodeToNetworkWriteRequest); end
    bus.txValid = 1'b1; bus.txDestX = 3'd0; bus.txDestY = 3'd3;
    step();
    bus.txValid = 1'b0;
    #1;
    nTests++; if (txDropCount !== 16'd2 || bus.nodeToNetworkWriteRequest !== 1'b0) begin nFail++; $display("FAIL drop_y: got cnt=%0d wr=%b exp cnt=2 wr=0", txDropCount, bus.nodeToNetworkWriteRequest); end
    bus.txValid = 1'b1; bus.txDestX = 3'd2; bus.txDestY = 3'd2;
    step();
    bus.txValid = 1'b0;
    #1;
    nTests++; if (txDropCount !== 16'd2 || bus.nodeToNetworkWriteRequest !== 1'b1) begin nFail++; $display("FAIL drop_edge_legal: got cnt=%0d wr=%b exp cnt=2 wr=1", txDropCount, bus.nodeToNetworkWriteRequest); end
    step();
  endtask

  task automatic test_rx_overflow();
    bus.rxReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.networkToNodeWriteRequest = 1'b1;
      bus.networkToNodeData = mkPkt(3'd1, 3'd1, 3'd0, 3'd0, 52'h200 + 52'(i));
      #1;
      nTests++; if (bus.nodeToNetworkHoldRequest !== 1'b0) begin nFail++; $display("FAIL rx_fill%0d_hold: got %b exp 0", i, bus.nodeToNetworkHoldRequest); end
      step();
    end
    bus.networkToNodeWriteRequest = 1'b0;
    #1;
    nTests++; if (bus.nodeToNetworkHoldRequest !== 1'b1 || bus.rxValid !== 1'b1) begin nFail++; $display("FAIL rx_full: got hold=%b valid=%b exp 1 1", bus.nodeToNetworkHoldRequest, bus.rxValid); end
    bus.networkToNodeWriteRequest = 1'b1;
    bus.networkToNodeData = mkPkt(3'd1, 3'd1, 3'd0, 3'd0, 52'h204);
    step();
    bus.networkToNodeWriteRequest = 1'b0;
    #1;
    nTests++; if (rxOverflowCount !== 16'd1) begin nFail++; $display("FAIL rx_overflow1: got %0d exp 1", rxOverflowCount); end
    nTests++; if (bus.rxData !== mkPkt(3'd1, 3'd1, 3'd0, 3'd0, 52'h200)) begin nFail++; $display("FAIL rx_head_kept: got %h exp %h", bus.rxData, mkPkt(3'd1, 3'd1, 3'd0, 3'd0, 52'h200)); end
    // Pop and write together while full: the write is still lost
    bus.networkToNodeWriteRequest = 1'b1;
    bus.networkToNodeData = mkPkt(3'd1, 3'd1, 3'd0, 3'd0, 52'h205);
    bus.rxReady = 1'b1;
    step();
    bus.networkToNodeWriteRequest = 1'b0;
    #1;
    nTests++; if (rxOverflowCount !== 16'd2 || bus.nodeToNetworkHoldRequest !== 1'b0) begin nFail++; $display("FAIL rx_overflow_pop: got cnt=%0d hold=%b exp cnt=2 hold=0", rxOverflowCount, bus.nodeToNetworkHoldRequest); end
    for (int i = 1; i < 4; i++) begin
      nTests++; if (bus.rxData !== mkPkt(3'd1, 3'd1, 3'd0, 3'd0, 52'h200 + 52'(i))) begin nFail++; $display("FAIL rx_drain%0d: got %h exp %h", i, bus.rxData, mkPkt(3'd1, 3'd1, 3'd0, 3'd0, 52'h200 + 52'(i))); end
      step();
    end
    bus.rxReady = 1'b0;
    #1;
    nTests++; if (bus.rxValid !== 1'b0 || misrouteCount !== 16'd0) begin nFail++; $display("FAIL rx_empty: got valid=%b misroute=%0d exp 0 0", bus.rxValid, misrouteCount); end
  endtask

  task automatic test_misroute();
    bus.networkToNodeWriteRequest = 1'b1;
    bus.networkToNodeData = mkPkt(3'd0, 3'd2, 3'd2, 3'd2, 52'hABC);
    step();
    bus.networkToNodeWriteRequest = 1'b0;
    #1;
    nTests++; if (misrouteCount !== 16'd1) begin nFail++; $display("FAIL misroute_cnt: got %0d exp 1", misrouteCount); end
    nTests++; if (bus.rxValid !== 1'b1 || bus.rxData !== mkPkt(3'd0, 3'd2, 3'd2, 3'd2, 52'hABC)) begin nFail++; $display("FAIL misroute_deliver: got valid=%b data=%h exp 1 %h", bus.rxValid, bus.rxData, mkPkt(3'd0, 3'd2, 3'd2, 3'd2, 52'hABC)); end
    bus.rxReady = 1'b1;
    step();
    bus.rxReady = 1'b0;
    #1;
    nTests++; if (bus.rxValid !== 1'b0) begin nFail++; $display("FAIL misroute_pop: got %b exp 0", bus.rxValid); end
  endtask

  task automatic test_saturation();
    logic [1:0] expCnt;
    bus2.txValid = 1'b1; bus2.txDestX = 3'd5; bus2.txDestY = 3'd0; bus2.txPayload = 52'h1;
    for (int i = 0; i < 5; i++) begin
      step();
      expCnt = (i < 3) ? 2'(i + 1) : 2'd3;
      nTests++; if (satDrop !== expCnt || bus2.nodeToNetworkWriteRequest !== 1'b0) begin nFail++; $display("FAIL sat_drop%0d: got cnt=%0d wr=%b exp cnt=%0d wr=0", i, satDrop, bus2.nodeToNetworkWriteRequest, expCnt); end
    end
    bus2.txValid = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.networkToNodeHoldRequest = 1'b1;
    bus.rxReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.txValid = 1'b1; bus.txDestX = 3'd0; bus.txDestY = 3'd1; bus.txPayload = 52'h300 + 52'(i);
      bus.networkToNodeWriteRequest = 1'b1;
      bus.networkToNodeData = mkPkt(3'd1, 3'd1, 3'd2, 3'd0, 52'h400 + 52'(i));
      step();
    end
    bus.txValid = 1'b0;
    bus.networkToNodeWriteRequest = 1'b0;
    #1;
    nTests++; if (bus.rxValid !== 1'b1 || txDropCount !== 16'd2) begin nFail++; $display("FAIL ar_preload: got valid=%b drops=%0d exp 1 2", bus.rxValid, txDropCount); end
    #2;
    reset = 1'b1;
    bus.networkToNodeHoldRequest = 1'b0;
    #1;
    nTests++; if (bus.txReady !== 1'b1 || bus.nodeToNetworkWriteRequest !== 1'b0 || bus.nodeToNetworkData !== 64'h0) begin nFail++; $display("FAIL ar_tx: got ready=%b wr=%b data=%h exp 1 0 0", bus.txReady, bus.nodeToNetworkWriteRequest, bus.nodeToNetworkData); end
    nTests++; if (bus.rxValid !== 1'b0 || bus.rxData !== 64'h0 || bus.nodeToNetworkHoldRequest !== 1'b0) begin nFail++; $display("FAIL ar_rx: got valid=%b data=%h hold=%b exp 0 0 0", bus.rxValid, bus.rxData, bus.nodeToNetworkHoldRequest); end
    nTests++; if ({txDropCount, rxOverflowCount, misrouteCount} !== 48'h0) begin nFail++; $display("FAIL ar_counters: got %h exp 0", {txDropCount, rxOverflowCount, misrouteCount}); end
    step();
    reset = 1'b0;
    step();
    nTests++; if (bus.rxValid !== 1'b0 || bus.nodeToNetworkWriteRequest !== 1'b0) begin nFail++; $display("FAIL ar_after: got valid=%b wr=%b exp 0 0", bus.rxValid, bus.nodeToNetworkWriteRequest); end
  endtask

  initial begin
    bus.txPayload = '0; bus.txDestX = '0; bus.txDestY = '0; bus.txValid = 1'b0;
    bus.networkToNodeData = '0; bus.networkToNodeWriteRequest = 1'b0;
    bus.networkToNodeHoldRequest = 1'b0; bus.rxReady = 1'b0;
    bus2.txPayload = '0; bus2.txDestX = '0; bus2.txDestY = '0; bus2.txValid = 1'b0;
    bus2.networkToNodeData = '0; bus2.networkToNodeWriteRequest = 1'b0;
    bus2.networkToNodeHoldRequest = 1'b0; bus2.rxReady = 1'b0;

    test_reset();
    test_inject();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_rx_overflow();
    test_misroute();
    test_saturation();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
